// File: rtl/sync_fifo.sv
// Single-clock FIFO with binary wrap-bit pointers, registered status flags,
// programmable almost thresholds, sticky error flags and optional FWFT output.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 3,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [ADDR_SIZE:0]    af_level,
  input  logic [ADDR_SIZE:0]    ae_level,
  output logic [DATA_WIDTH-1:0] out,
  output logic [ADDR_SIZE:0]    count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_C = {1'b1, {ADDR_SIZE{1'b0}}};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_SIZE:0]    r_wptr, r_rptr, r_count;
  logic                  r_empty, r_full, r_aempty, r_afull, r_ovf, r_unf;

  logic                  w_wr, w_rd, w_mem_we;
  logic [ADDR_SIZE:0]    w_wptr_next, w_rptr_next, w_count_next;
  logic [ADDR_SIZE-1:0]  w_waddr, w_raddr;

  // Acceptance is decided from the flags registered at the start of the cycle.
  assign w_wr     = w_en & ~r_full  & ~flush;
  assign w_rd     = r_en & ~r_empty & ~flush;
  assign w_mem_we = w_wr & ~rst;
  assign w_waddr  = r_wptr[ADDR_SIZE-1:0];
  assign w_raddr  = r_rptr[ADDR_SIZE-1:0];

  always_comb begin
    w_wptr_next = r_wptr + {{ADDR_SIZE{1'b0}}, w_wr};
    w_rptr_next = r_rptr + {{ADDR_SIZE{1'b0}}, w_rd};
    if (flush) begin
      w_wptr_next = '0;
      w_rptr_next = '0;
    end
    w_count_next = w_wptr_next - w_rptr_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_next;
      r_rptr   <= w_rptr_next;
      r_count  <= w_count_next;
      r_empty  <= (w_count_next == '0);
      r_full   <= (w_count_next == DEPTH_C);
      r_aempty <= (w_count_next <= ae_level);
      r_afull  <= (w_count_next >= af_level) & ~flush;
      if (w_en & r_full)
        r_ovf <= 1'b1;
      if (r_en & r_empty)
        r_unf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we)
      r_mem[w_waddr] <= w_data;
  end

  generate
    if (FWFT) begin : gen_fwft
      // Head word is shown straight from the array; zero while empty keeps out defined.
      assign out = r_empty ? '0 : r_mem[w_raddr];
    end else begin : gen_std
      logic [DATA_WIDTH-1:0] r_out;
      always_ff @(posedge clk) begin
        if (rst)
          r_out <= '0;
        else if (w_rd)
          r_out <= r_mem[w_raddr];
      end
      assign out = r_out;
    end
  endgenerate

  assign count        = r_count;
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_aempty;
  assign almost_full  = r_afull;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a standard-mode instance driven through a
// reference model, plus a small FWFT instance checked directly.
module tb_sync_fifo;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // standard-mode instance
  logic       rst, flush, w_en, r_en;
  logic [7:0] w_data, out;
  logic [3:0] af_level, ae_level, count;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;

  // FWFT instance
  logic       f_rst, f_flush, f_w_en, f_r_en;
  logic [7:0] f_w_data, f_out;
  logic [3:0] f_count;
  logic       f_empty, f_full, f_ae, f_af, f_ovf, f_unf;

  sync_fifo #(.DATA_WIDTH(8), .ADDR_SIZE(3), .FWFT(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .w_data(w_data), .w_en(w_en), .r_en(r_en),
    .af_level(af_level), .ae_level(ae_level), .out(out), .count(count),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo #(.DATA_WIDTH(8), .ADDR_SIZE(3), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst(f_rst), .flush(f_flush), .w_data(f_w_data), .w_en(f_w_en), .r_en(f_r_en),
    .af_level(af_level), .ae_level(ae_level), .out(f_out), .count(f_count),
    .empty(f_empty), .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
    .overflow(f_ovf), .underflow(f_unf)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  logic [7:0] sb_q[$];
  int         m_count;
  logic [7:0] m_out;
  logic       m_ovf, m_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, " count"}, 32'(count), 32'(m_count));
    check({tag, " empty"}, 32'(empty), 32'(m_count == 0));
    check({tag, " full"},  32'(full),  32'(m_count == 8));
    check({tag, " ae"},    32'(almost_empty), 32'(m_count <= int'(ae_level)));
    check({tag, " af"},    32'(almost_full),  32'(m_count >= int'(af_level)));
    check({tag, " ovf"},   32'(overflow),  32'(m_ovf));
    check({tag, " unf"},   32'(underflow), 32'(m_unf));
    check({tag, " out"},   32'(out), 32'(m_out));
  endtask

  // one clock of stimulus on the standard instance, then model update and checks
  task automatic cycle(input logic we, input logic re, input logic [7:0] d, input string tag);
    bit acc_w, acc_r;
    acc_w  = we && (m_count < 8);
    acc_r  = re && (m_count > 0);
    m_ovf |= we && (m_count == 8);
    m_unf |= re && (m_count == 0);
    w_en = we; r_en = re; w_data = d;
    @(posedge clk); #1;
    w_en = 1'b0; r_en = 1'b0;
    if (acc_w) sb_q.push_back(d);
    if (acc_r) m_out = sb_q.pop_front();
    m_count = m_count + int'(acc_w) - int'(acc_r);
    $display("%s: we=%0d re=%0d din=%02h out=%02h count=%0d", tag, we, re, d, out, count);
    check_status(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; w_en = 1'b1; r_en = 1'b1; w_data = 8'hEE;
    @(posedge clk); #1;
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
    sb_q.delete(); m_count = 0; m_out = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    $display("%s: reset", tag);
    check_status(tag);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; w_data = 8'h00;
    af_level = 4'd6; ae_level = 4'd1;
    f_rst = 1'b1; f_flush = 1'b0; f_w_en = 1'b0; f_r_en = 1'b0; f_w_data = 8'h00;
    m_count = 0; m_out = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;

    do_reset("t1_rst");
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'(i), "t1_wr");

    cycle(1'b1, 1'b0, 8'h99, "t2_ovf");
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00, "t2_rd");

    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h10 + i), "t3_fill");
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'(8'h14 + i), "t3_rw");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00, "t3_drain");

    cycle(1'b0, 1'b1, 8'h00, "t4_unf");
    cycle(1'b1, 1'b1, 8'h5A, "t4_wr_rd_empty");
    cycle(1'b1, 1'b1, 8'h5B, "t4_both");
    cycle(1'b0, 1'b1, 8'h00, "t4_rd");

    // full with simultaneous read: pop accepted, write rejected
    do_reset("t6_rst0");
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i), "t6_fill8");
    cycle(1'b1, 1'b1, 8'hAB, "t6_full_rw");
    cycle(1'b1, 1'b0, 8'h38, "t6_refill");
    cycle(1'b1, 1'b0, 8'h39, "t6_ovf");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00, "t6_to5");

    flush = 1'b1; w_en = 1'b1; r_en = 1'b1; w_data = 8'h77;
    @(posedge clk); #1;
    flush = 1'b0; w_en = 1'b0; r_en = 1'b0;
    sb_q.delete(); m_count = 0;
    $display("t6_flush: count=%0d ovf=%0d", count, overflow);
    check_status("t6_flush");

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i), "t6_burst");
    cycle(1'b0, 1'b1, 8'h00, "t6_burst_rd");
    do_reset("t6_midrst");
    cycle(1'b1, 1'b0, 8'h42, "t6_post_wr");
    cycle(1'b0, 1'b1, 8'h00, "t6_post_rd");

    // FWFT instance
    @(posedge clk); #1;
    f_rst = 1'b0;
    check("t5_rst_empty", 32'(f_empty), 32'd1);
    check("t5_rst_count", 32'(f_count), 32'd0);
    f_w_en = 1'b1; f_w_data = 8'hA5;
    @(posedge clk); #1;
    f_w_en = 1'b0;
    $display("t5_wr: empty=%0d out=%02h", f_empty, f_out);
    check("t5_empty", 32'(f_empty), 32'd0);
    check("t5_out", 32'(f_out), 32'hA5);
    f_w_en = 1'b1; f_w_data = 8'hB6;
    @(posedge clk); #1;
    f_w_en = 1'b0;
    check("t5_head_held", 32'(f_out), 32'hA5);
    f_r_en = 1'b1;
    @(posedge clk); #1;
    f_r_en = 1'b0;
    $display("t5_pop1: empty=%0d out=%02h", f_empty, f_out);
    check("t5_adv", 32'(f_out), 32'hB6);
    check("t5_cnt1", 32'(f_count), 32'd1);
    f_r_en = 1'b1;
    @(posedge clk); #1;
    f_r_en = 1'b0;
    $display("t5_pop2: empty=%0d", f_empty);
    check("t5_empty_end", 32'(f_empty), 32'd1);
    check("t5_unf", 32'(f_unf), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
